// File: rtl/systolic_result_collector.sv
// Assembles 2x2 systolic results into matrices, queues them in a FIFO and streams them row-major.
// Optional SYSTOLIC_COLLECT_RELU_EN clamps negative accumulators to zero at capture.
module systolic_result_collector #(
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned AXIS_W = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        v,
  input  logic [AXIS_W-1:0] x,
  input  logic [AXIS_W-1:0] y,
  input  logic [ACC_W-1:0]  c1,
  input  logic [ACC_W-1:0]  c2,
  input  logic [ACC_W-1:0]  c3,
  input  logic [ACC_W-1:0]  c4,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_row,
  output logic              out_col,
  output logic [AXIS_W-1:0] out_tag_x,
  output logic [AXIS_W-1:0] out_tag_y,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              seq_err,
  output logic              busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StGot1, StGot2} state_e;

  state_e              state_q;
  logic [ACC_W-1:0]    slot0_q, slot1_q, slot2_q;
  logic [AXIS_W-1:0]   tag_x_q, tag_y_q;
  logic [ACC_W-1:0]    mem_data [DEPTH][4];
  logic [AXIS_W-1:0]   mem_x [DEPTH];
  logic [AXIS_W-1:0]   mem_y [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       count_q;
  logic [1:0]          elem_q;
  logic                overflow_q, seq_err_q;

  logic fifo_empty, fifo_full, beat, pop, push_req, push;

  function automatic logic [ACC_W-1:0] capture(input logic [ACC_W-1:0] val);
`ifdef SYSTOLIC_COLLECT_RELU_EN
    return val[ACC_W-1] ? '0 : val;
`else
    return val;
`endif
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PtrW+1)'(DEPTH));
  assign out_valid  = !fifo_empty;
  assign beat       = out_valid && out_ready;
  assign pop        = beat && (elem_q == 2'd3);
  assign push_req   = (state_q == StGot2) && (v == 2'd3);
  // A full FIFO still accepts the push if the head is leaving on this same edge.
  assign push       = push_req && (!fifo_full || pop);
  assign overflow   = overflow_q;
  assign seq_err    = seq_err_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;

  always_comb begin
    out_data  = '0;
    out_row   = 1'b0;
    out_col   = 1'b0;
    out_last  = 1'b0;
    out_tag_x = '0;
    out_tag_y = '0;
    if (out_valid) begin
      out_data  = mem_data[rd_ptr_q][elem_q];
      out_row   = elem_q[1];
      out_col   = elem_q[0];
      out_last  = (elem_q == 2'd3);
      out_tag_x = mem_x[rd_ptr_q];
      out_tag_y = mem_y[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_data[wr_ptr_q][0] <= slot0_q;
      mem_data[wr_ptr_q][1] <= slot1_q;
      mem_data[wr_ptr_q][2] <= slot2_q;
      mem_data[wr_ptr_q][3] <= capture(c4);
      mem_x[wr_ptr_q]       <= tag_x_q;
      mem_y[wr_ptr_q]       <= tag_y_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      slot0_q    <= '0;
      slot1_q    <= '0;
      slot2_q    <= '0;
      tag_x_q    <= '0;
      tag_y_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      elem_q     <= '0;
      overflow_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (beat) elem_q   <= elem_q + 2'd1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (push_req && !push) overflow_q <= 1'b1;

      case (v)
        2'd1: begin
          // A new first phase always restarts assembly; a partial matrix is abandoned.
          slot0_q <= capture(c1);
          tag_x_q <= x;
          tag_y_q <= y;
          state_q <= StGot1;
          if (state_q != StIdle) seq_err_q <= 1'b1;
        end
        2'd2: begin
          if (state_q == StGot1) begin
            slot1_q <= capture(c2);
            slot2_q <= capture(c3);
            state_q <= StGot2;
          end else begin
            seq_err_q <= 1'b1;
          end
        end
        2'd3: begin
          if (state_q == StGot2) state_q <= StIdle;
          else                   seq_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed self-checking bench for systolic_result_collector (default parameters).
module tb_systolic_result_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  v;
  logic [2:0]  x, y;
  logic [15:0] c1, c2, c3, c4;
  logic [15:0] out_data;
  logic        out_row, out_col, out_last, out_valid, out_ready;
  logic [2:0]  out_tag_x, out_tag_y;
  logic        overflow, seq_err, busy;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef SYSTOLIC_COLLECT_RELU_EN
  localparam logic [15:0] ReluFirst = 16'h0000;
`else
  localparam logic [15:0] ReluFirst = 16'hFFF6;
`endif

  systolic_result_collector dut (
    .clk       (clk),
    .reset     (reset),
    .v         (v),
    .x         (x),
    .y         (y),
    .c1        (c1),
    .c2        (c2),
    .c3        (c3),
    .c4        (c4),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_tag_x (out_tag_x),
    .out_tag_y (out_tag_y),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .seq_err   (seq_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] tx, input logic [2:0] ty, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    v = 2'd1; x = tx; y = ty; c1 = a;
    tick();
    v = 2'd2; c2 = b; c3 = c;
    tick();
    v = 2'd3; c4 = d;
    tick();
    v = 2'd0;
  endtask

  // Expects out_ready=1 and the matrix at the head on entry; consumes all four beats.
  task automatic drain(input string tag, input logic [2:0] tx, input logic [2:0] ty,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [15:0] d);
    logic [15:0] exp [4];
    exp[0] = a; exp[1] = b; exp[2] = c; exp[3] = d;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(out_data), 32'(exp[i]));
      check({tag, "_row"}, 32'(out_row), 32'(i / 2));
      check({tag, "_col"}, 32'(out_col), 32'(i % 2));
      check({tag, "_last"}, 32'(out_last), 32'(i == 3));
      check({tag, "_tagx"}, 32'(out_tag_x), 32'(tx));
      check({tag, "_tagy"}, 32'(out_tag_y), 32'(ty));
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; v = 2'd0; x = '0; y = '0;
    c1 = '0; c2 = '0; c3 = '0; c4 = '0; out_ready = 1'b0;
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_rowcol", {30'd0, out_row, out_col}, 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_tags", {26'd0, out_tag_x, out_tag_y}, 32'd0);
    check("rst_flags", {29'd0, overflow, seq_err, busy}, 32'd0);
    reset = 1'b0;

    // Single matrix, streamed at full rate.
    out_ready = 1'b1;
    v = 2'd1; x = 3'd2; y = 3'd5; c1 = 16'd7;
    tick();
    check("single_busy", 32'(busy), 32'd1);
    v = 2'd2; c2 = 16'd9; c3 = 16'd11;
    tick();
    v = 2'd3; c4 = 16'd13;
    tick();
    v = 2'd0;
    drain("single", 3'd2, 3'd5, 16'd7, 16'd9, 16'd11, 16'd13);
    check("single_end_valid", 32'(out_valid), 32'd0);
    check("single_end_busy", 32'(busy), 32'd0);

    // Backpressure holds the first element.
    out_ready = 1'b0;
    send(3'd1, 3'd6, 16'd7, 16'd9, 16'd11, 16'd13);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'd7);
      check("bp_rowcol", {30'd0, out_row, out_col}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    drain("bp", 3'd1, 3'd6, 16'd7, 16'd9, 16'd11, 16'd13);
    check("bp_end_valid", 32'(out_valid), 32'd0);

    // Negative accumulator: clamped only when ReLU is built in.
    send(3'd0, 3'd1, 16'hFFF6, 16'd20, 16'd30, 16'd40);
    drain("relu", 3'd0, 3'd1, ReluFirst, 16'd20, 16'd30, 16'd40);

    // Overflow: five matrices into a four-deep FIFO with no consumer.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(3'(k), 3'(k + 1), 16'(k * 4 + 1), 16'(k * 4 + 2), 16'(k * 4 + 3), 16'(k * 4 + 4));
      if (k == 3) begin
        check("ovf_pre", 32'(overflow), 32'd0);
        check("ovf_busy", 32'(busy), 32'd1);
      end
    end
    check("ovf_set", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++)
      drain("ovf", 3'(k), 3'(k + 1), 16'(k * 4 + 1), 16'(k * 4 + 2), 16'(k * 4 + 3),
            16'(k * 4 + 4));
    check("ovf_end_valid", 32'(out_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Push into a full FIFO on the same edge the head's last beat is accepted.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      send(3'(k), 3'(k), 16'(100 + k), 16'(200 + k), 16'(300 + k), 16'(400 + k));
    out_ready = 1'b1;
    tick();
    send(3'd7, 3'd7, 16'd71, 16'd72, 16'd73, 16'd74);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    for (int k = 1; k < 4; k++)
      drain("fullpop", 3'(k), 3'(k), 16'(100 + k), 16'(200 + k), 16'(300 + k), 16'(400 + k));
    drain("fullpop_new", 3'd7, 3'd7, 16'd71, 16'd72, 16'd73, 16'd74);
    check("fullpop_end", 32'(out_valid), 32'd0);

    // Sequence errors: stray v=3, then a restarted assembly.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    v = 2'd3;
    tick();
    check("seq_v3_idle", 32'(seq_err), 32'd1);
    check("seq_v3_busy", 32'(busy), 32'd0);
    v = 2'd1; x = 3'd1; y = 3'd1; c1 = 16'd100;
    tick();
    send(3'd3, 3'd4, 16'd55, 16'd66, 16'd77, 16'd88);
    drain("seq", 3'd3, 3'd4, 16'd55, 16'd66, 16'd77, 16'd88);
    check("seq_one_only", 32'(out_valid), 32'd0);

    // Reset mid-stream after two accepted beats.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    v = 2'd2;
    tick();
    v = 2'd0;
    check("mid_seq_pre", 32'(seq_err), 32'd1);
    send(3'd1, 3'd2, 16'd5, 16'd6, 16'd7, 16'd8);
    tick();
    tick();
    check("mid_data_pre", 32'(out_data), 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_flags", {30'd0, overflow, seq_err}, 32'd0);
    check("mid_data", 32'(out_data), 32'd0);
    tick();
    check("mid_valid_after", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_result_collector.md
# systolic_result_collector

Downstream stage of the 2x2 systolic matrix-multiply control unit. It watches the control unit's `v` phase code and the four PE accumulator outputs, assembles the 2x2 result matrix, and tags it with the control unit's `x`/`y` indices. Completed matrices are queued in a small FIFO and streamed out one element per beat, row-major, over a valid/ready handshake.

## Interface
Parameters:
- `ACC_W`, default 16: PE accumulator / result width (two's complement).
- `AXIS_W`, default 3: width of the `x`/`y` tag, matching the control unit's axis width.
- `DEPTH`, default 4: FIFO depth in whole matrices. Must be a power of two, ≥2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `v` in 2: phase code from the control unit (0 idle, 1 PE1 done, 2 PE2+PE3 done, 3 PE4 done).
- `x`, `y` in `AXIS_W` each: tile indices, sampled only when `v`=1.
- `c1`, `c2`, `c3`, `c4` in `ACC_W` each: PE accumulators for C[0][0], C[0][1], C[1][0], C[1][1].
- `out_data` out `ACC_W`: current result element.
- `out_row`, `out_col` out 1 each: element position in the matrix.
- `out_tag_x`, `out_tag_y` out `AXIS_W` each: tags of the matrix being streamed.
- `out_last` out 1: high on the C[1][1] beat.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `overflow` out 1: sticky; set when a matrix is dropped because the FIFO is full.
- `seq_err` out 1: sticky; set on an out-of-order phase code.
- `busy` out 1: high when assembly is not IDLE or the FIFO is non-empty.

## Operation
- Assembly FSM states: IDLE, GOT1, GOT2.
  - IDLE, `v`=1: capture `c1`→slot0, latch `x`,`y`; go to GOT1.
  - GOT1, `v`=2: capture `c2`→slot1, `c3`→slot2; go to GOT2.
  - GOT2, `v`=3: capture `c4`→slot3; push {slots, tags} into the FIFO; go to IDLE.
  - `v`=1 in GOT1 or GOT2: discard the partial matrix, restart as for IDLE, set `seq_err`.
  - `v`=2 or `v`=3 in any state other than its expected one: ignored; set `seq_err`; state is unchanged.
  - `v`=0: no action.
- Push when the FIFO is full:
  - If the final beat (`out_last && out_valid && out_ready`) completes in the same cycle, the push succeeds.
  - Otherwise the matrix is dropped, `overflow` is set, and the FSM still returns to IDLE.
- Serializer:
  - While the FIFO is non-empty, `out_valid`=1. A 2-bit element counter selects the head-matrix element in order (0,0),(0,1),(1,0),(1,1).
  - Each accepted beat (`out_valid && out_ready`) advances the counter. On acceptance of the `out_last` beat, the counter wraps to 0 and the head is popped.
- `out_data`, `out_row`, `out_col`, `out_tag_*` and `out_last` hold steady while `out_valid && !out_ready`.
- FIFO pointers wrap modulo `DEPTH`. A separate occupancy count of width log2(`DEPTH`)+1 distinguishes full from empty.

## Timing
- Reset (synchronous) sets:
  - FSM to IDLE, FIFO empty, element counter to 0.
  - `out_valid`=0, `out_last`=0, `out_row`=`out_col`=0, `out_data`=0, `out_tag_x`=`out_tag_y`=0.
  - `overflow`=0, `seq_err`=0, `busy`=0.
- Reset mid-assembly or mid-stream discards everything. The next cycle behaves as post-reset.
- Capture latency: `c*` values are sampled in the same cycle the corresponding `v` code is present.
- Push latency: a matrix completed by `v`=3 in cycle t is visible at the output (`out_valid`=1, first element) in cycle t+1 if the FIFO was empty.
- Throughput: one element per cycle with `out_ready` held high. A full matrix drains in 4 cycles, faster than the control unit's 8-cycle repeat.
- Output fields are driven from the registered FIFO head and counter (a mux only, no extra register stage).

## Configuration
- `SYSTOLIC_COLLECT_RELU_EN` defined: each captured accumulator value with its MSB set (negative) is stored as 0 (ReLU at capture). The FIFO contents and `out_data` are never negative.
- `SYSTOLIC_COLLECT_RELU_EN` undefined: values are stored and emitted unchanged.

## Test plan
- Single matrix:
  - Stimulus: `v`=1 (x=2, y=5, c1=7), then `v`=2 (c2=9, c3=11), then `v`=3 (c4=13), with `out_ready`=1.
  - Response: the next cycle begins output 7, 9, 11, 13 on consecutive cycles; row/col = 00, 01, 10, 11; `out_last` only on 13; tags 2/5; then `out_valid`=0.
- Backpressure:
  - Stimulus: same matrix with `out_ready`=0 for 3 cycles after the first beat.
  - Response: `out_data`=7 and row/col=00 held stable; then streaming resumes with no loss or duplication.
- Overflow (`DEPTH`=4, `out_ready`=0):
  - Stimulus: 5 matrices.
  - Response: the first 4 are stored, the fifth is dropped, `overflow`=1. Draining yields exactly 4 matrices in order.
- Sequence error:
  - Stimulus: `v`=3 while IDLE, then `v`=1, `v`=1, `v`=2, `v`=3.
  - Response: `seq_err`=1; exactly one matrix is emitted, using the c1 and tags from the second `v`=1.
- Reset mid-stream:
  - Stimulus: assert `reset` for 1 cycle after 2 beats.
  - Response: the next cycle has `out_valid`=0, `busy`=0, and both sticky flags cleared.
- ReLU (with `SYSTOLIC_COLLECT_RELU_EN` defined):
  - Stimulus: c1=16'hFFF6 (−10), other results positive.
  - Response: the first emitted element is 0 and the others are unchanged. Without the macro, the first element is 16'hFFF6.
